// File: rtl/sphere_area_sched.sv
// sphere_area_sched: round-robin scheduler sharing one sphere-area datapath
// between NUM_REQ requesters. One job in flight; results are returned tagged
// with the requester ID over a valid/ready port.
// Optional feature macro: SPHERE_AREA_SCHED_ZERO_BYPASS_EN
//   defined   -> a granted radius of 0 skips the datapath (area 0, no error)
//   undefined -> radius 0 runs through the datapath like any other value

module sphere_area_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 6,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [16*NUM_REQ-1:0]      req_radius,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       dp_en,
  output logic [15:0]                dp_radius,
  input  logic [25:0]                dp_area,
  input  logic                       dp_rdy,
  output logic                       res_valid,
  output logic [25:0]                res_area,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic                       res_err,
  input  logic                       res_ready,
  output logic                       busy
);

  localparam int unsigned ID_W   = $clog2(NUM_REQ);
  localparam int unsigned RAD_W  = 16;
  localparam int unsigned AREA_W = 26;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

  // Elaboration-time parameter sanity checks
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("sphere_area_sched: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT <= LATENCY) begin : g_bad_timeout
    $error("sphere_area_sched: TIMEOUT must exceed LATENCY");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ID_W-1:0]     rr_ptr;
  logic [RAD_W-1:0]    rad_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                grant_hit;
  logic [ID_W-1:0]     grant_id;
  logic [RAD_W-1:0]    grant_rad;
  logic                load_job;
  logic                cap_ok;
  logic                cap_err;
  logic                cap_zero;

  // Round-robin pick: first requester at or after rr_ptr, wrapping
  always_comb begin : arb
    int unsigned idx;
    idx       = 0;
    grant_hit = 1'b0;
    grant_id  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!grant_hit && req_valid[ID_W'(idx)]) begin
        grant_hit = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  // Radius of the requester currently being picked
  always_comb begin : grant_rad_mux
    grant_rad = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        grant_rad = req_radius[RAD_W*k +: RAD_W];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and per-cycle control strobes
  always_comb begin : fsm_next
    state_d   = state_q;
    req_ready = '0;
    load_job  = 1'b0;
    cap_ok    = 1'b0;
    cap_err   = 1'b0;
    cap_zero  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_hit) begin
          req_ready[grant_id] = 1'b1;
          load_job            = 1'b1;
          state_d             = ST_RUN;
`ifdef SPHERE_AREA_SCHED_ZERO_BYPASS_EN
          if (grant_rad == '0) begin
            cap_zero = 1'b1;
            state_d  = ST_OUT;
          end
`endif
        end
      end
      ST_RUN: begin
        // A result arriving on the last allowed cycle still wins over the abort
        if (dp_rdy) begin
          cap_ok  = 1'b1;
          state_d = ST_OUT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cap_err = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Job registers: pointer, radius, cycle counter and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      rad_q     <= '0;
      cnt_q     <= '0;
      res_valid <= 1'b0;
      res_area  <= '0;
      res_id    <= '0;
      res_err   <= 1'b0;
    end else begin
      res_valid <= (state_d == ST_OUT);
      if (load_job) begin
        rad_q  <= grant_rad;
        res_id <= grant_id;
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
      if (state_q == ST_RUN) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
      if (cap_ok) begin
        res_area <= dp_area;
        res_err  <= 1'b0;
      end else if (cap_err || cap_zero) begin
        res_area <= AREA_W'(0);
        res_err  <= cap_err;
      end
    end
  end

  // Datapath drive and status decoded from registered state
  assign dp_en     = (state_q == ST_RUN);
  assign dp_radius = rad_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sphere_area_sched.sv
// tb_sphere_area_sched: table vectors, hand-written corner sequences and a
// randomized phase checked against a job-level reference model.

module tb_sphere_area_sched;

  localparam int NUM_REQ = 4;
  localparam int LATENCY = 6;
  localparam int TIMEOUT = 15;
  localparam int ID_W    = $clog2(NUM_REQ);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [16*NUM_REQ-1:0] req_radius = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  dp_en;
  logic [15:0]           dp_radius;
  logic [25:0]           dp_area;
  logic                  dp_rdy;
  logic                  res_valid;
  logic [25:0]           res_area;
  logic [ID_W-1:0]       res_id;
  logic                  res_err;
  logic                  res_ready = 1'b0;
  logic                  busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Datapath stand-in: result appears lat cycles after the first enabled cycle
  int          lat      = LATENCY;
  int          en_cnt   = 0;
  bit          noise_on = 1'b0;
  logic        noise_q  = 1'b0;
  logic [25:0] junk     = '0;
  int          ptr_m    = 0;

  sphere_area_sched #(
    .NUM_REQ(NUM_REQ),
    .LATENCY(LATENCY),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_radius(req_radius),
    .req_ready (req_ready),
    .dp_en     (dp_en),
    .dp_radius (dp_radius),
    .dp_area   (dp_area),
    .dp_rdy    (dp_rdy),
    .res_valid (res_valid),
    .res_area  (res_area),
    .res_id    (res_id),
    .res_err   (res_err),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] area_fn(input logic [15:0] r);
    longint unsigned t;
    t = longint'(r) * longint'(r) * 201 / 16;
    return 26'(t);
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    en_cnt  <= dp_en ? en_cnt + 1 : 0;
    junk    <= 26'($urandom);
    noise_q <= noise_on && (($urandom % 2) == 1);
  end

  assign dp_rdy  = dp_en ? (en_cnt >= lat) : noise_q;
  assign dp_area = (dp_en && en_cnt >= lat) ? area_fn(dp_radius) : junk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: round-robin pick over a request mask
  function automatic int pick(input logic [NUM_REQ-1:0] m, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Reference: outcome of one job from its radius and datapath latency
  function automatic void expect_job(input logic [15:0] r, input int l,
                                     output logic [25:0] a, output logic e,
                                     output int lt);
`ifdef SPHERE_AREA_SCHED_ZERO_BYPASS_EN
    if (r == 16'd0) begin
      a = '0; e = 1'b0; lt = 1;
      return;
    end
`endif
    if (l <= TIMEOUT - 1) begin
      a = area_fn(r); e = 1'b0; lt = l + 2;
    end else begin
      a = '0; e = 1'b1; lt = TIMEOUT + 1;
    end
  endfunction

  // One full job: grant, run, result (optional backpressure), gap
  task automatic run_job(input string tag, input int bp, input int exp_id,
                         input logic [25:0] exp_area, input logic exp_err,
                         input int exp_lat, input bit drop, output int t_g);
    int          n;
    int          en_n;
    int          t_v;
    int          gid;
    bit          bad;
    logic [15:0] rad;
    logic [25:0] a_h;
    logic [ID_W-1:0] i_h;
    logic        e_h;
    t_g = cyc;
    n   = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == '0) begin
      n_chk++; n_fail++;
      $display("FAIL %s_grant: no req_ready within 100 cycles", tag);
      return;
    end
    gid = 0;
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gid = i;
    chk({tag, "_onehot"}, 64'($onehot(req_ready)), 64'd1);
    chk({tag, "_gid"}, 64'(gid), 64'(exp_id));
    t_g = cyc;
    rad = req_radius[gid*16 +: 16];
    bad = busy;
    if (drop) begin
      @(posedge clk); #1;
      req_valid = '0;
    end
    en_n = 0;
    n    = 0;
    @(negedge clk);
    while (!res_valid && n < 60) begin
      if (dp_en) begin
        en_n++;
        if (dp_radius !== rad) bad = 1'b1;
      end
      if (req_ready != '0 || !busy) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      n_chk++; n_fail++;
      $display("FAIL %s_result: no res_valid within 60 cycles", tag);
      return;
    end
    t_v = cyc;
    chk({tag, "_lat"}, 64'(t_v - t_g), 64'(exp_lat));
    chk({tag, "_en_cycles"}, 64'(en_n), 64'(exp_lat - 1));
    chk({tag, "_area"}, 64'(res_area), 64'(exp_area));
    chk({tag, "_id"}, 64'(res_id), 64'(exp_id));
    chk({tag, "_err"}, 64'(res_err), 64'(exp_err));
    chk({tag, "_run_ok"}, 64'(bad), 64'd0);
    if (bp > 0) begin
      a_h = res_area; i_h = res_id; e_h = res_err; bad = 1'b0;
      @(posedge clk); #1;
      req_valid = '1;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        if (!res_valid || res_area !== a_h || res_id !== i_h || res_err !== e_h ||
            dp_en || req_ready != '0 || !busy) bad = 1'b1;
      end
      chk({tag, "_bp_hold"}, 64'(bad), 64'd0);
      @(posedge clk); #1;
      res_ready = 1'b1;
      req_valid = '0;
      @(negedge clk);
      chk({tag, "_hs_valid"}, 64'(res_valid), 64'd1);
    end
    @(negedge clk);
    chk({tag, "_gap"}, 64'({res_valid, busy, dp_en, |req_ready}), 64'(4'b0100));
  endtask

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    logic [15:0]        rad;
    int                 lat;
    int                 bp;
    int                 exp_id;
    logic               exp_err;
    int                 exp_lat;
    logic [25:0]        exp_area;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        tv[8];
    int          t_g;
    int          t_prev;
    int          gid;
    int          n;
    bit          bad;
    logic [25:0] ea;
    logic        ee;
    int          el;
    int          eid;
    logic [NUM_REQ-1:0] m;
    logic [15:0] r;

    tv[0] = '{4'b0010, 16'h0100,  6,  0, 1, 1'b0,  8, area_fn(16'h0100)};
    tv[1] = '{4'b1111, 16'h1234,  6,  0, 2, 1'b0,  8, area_fn(16'h1234)};
    tv[2] = '{4'b0011, 16'hFFFF, 14,  0, 0, 1'b0, 16, area_fn(16'hFFFF)};
    tv[3] = '{4'b0001, 16'h0007, 15,  0, 0, 1'b1, 16, 26'd0};
    tv[4] = '{4'b1000, 16'h00FF,  6, 20, 3, 1'b0,  8, area_fn(16'h00FF)};
`ifdef SPHERE_AREA_SCHED_ZERO_BYPASS_EN
    tv[5] = '{4'b0100, 16'h0000,  6,  0, 2, 1'b0,  1, 26'd0};
`else
    tv[5] = '{4'b0100, 16'h0000,  6,  0, 2, 1'b0,  8, 26'd0};
`endif
    tv[6] = '{4'b1010, 16'h8001,  1,  0, 3, 1'b0,  3, area_fn(16'h8001)};
    tv[7] = '{4'b1010, 16'h0555,  6,  0, 1, 1'b0,  8, area_fn(16'h0555)};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_dp_en", 64'(dp_en), 64'd0);
    chk("rst_dp_radius", 64'(dp_radius), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_area", 64'(res_area), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      lat        = tv[i].lat;
      req_radius = {NUM_REQ{tv[i].rad}};
      req_valid  = tv[i].mask;
      res_ready  = (tv[i].bp == 0);
      run_job($sformatf("vec%0d", i), tv[i].bp, tv[i].exp_id, tv[i].exp_area,
              tv[i].exp_err, tv[i].exp_lat, 1'b1, t_g);
    end

    // Round-robin with all requesters held valid
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    rst        = 1'b1;
    ptr_m      = 0;
    lat        = LATENCY;
    res_ready  = 1'b1;
    req_radius = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    @(posedge clk); #1;
    req_valid = '1;
    t_prev    = 0;
    for (int j = 0; j < 5; j++) begin
      eid = pick(req_valid, ptr_m);
      expect_job(req_radius[eid*16 +: 16], lat, ea, ee, el);
      run_job($sformatf("rr%0d", j), 0, eid, ea, ee, el, (j == 4), t_g);
      ptr_m = (eid + 1) % NUM_REQ;
      if (j > 0) chk($sformatf("rr%0d_period", j), 64'(t_g - t_prev), 64'(LATENCY + 4));
      t_prev = t_g;
    end

    // Reset in the middle of RUN
    @(posedge clk); #1;
    req_valid = '1;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    gid = -1;
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gid = i;
    chk("midrst_gid", 64'(gid), 64'(pick(4'b1111, ptr_m)));
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("midrst_en_before", 64'(dp_en), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_en_async", 64'({dp_en, busy, res_valid}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid || dp_en || busy) bad = 1'b1;
    end
    chk("midrst_quiet", 64'(bad), 64'd0);
    ptr_m = 0;
    @(posedge clk); #1;
    req_valid = '1;
    expect_job(req_radius[15:0], lat, ea, ee, el);
    run_job("midrst_next", 0, 0, ea, ee, el, 1'b1, t_g);
    ptr_m = 1;

    // Randomized jobs against the reference model
    noise_on = 1'b1;
    for (int j = 0; j < 40; j++) begin
      int bp;
      @(posedge clk); #1;
      m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        r = 16'($urandom);
        if ($urandom_range(0, 7) == 0) r = 16'd0;
        req_radius[i*16 +: 16] = r;
      end
      lat       = $urandom_range(0, TIMEOUT + 2);
      bp        = $urandom_range(0, 3);
      res_ready = (bp == 0);
      req_valid = m;
      eid       = pick(m, ptr_m);
      expect_job(req_radius[eid*16 +: 16], lat, ea, ee, el);
      run_job($sformatf("rnd%0d", j), bp, eid, ea, ee, el, 1'b1, t_g);
      ptr_m = (eid + 1) % NUM_REQ;
    end
    noise_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
